// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative 64-bit M-extension unit (shift-add multiply, restoring
//            divide, one bit per cycle) with 1-cycle divide special cases.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [2:0]  op,
    input  logic        word,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [63:0] r_x;        // accumulator (MUL) / partial remainder (DIV)
    logic [63:0] r_y;        // multiplier (MUL) / dividend-quotient (DIV)
    logic [63:0] r_z;        // multiplicand (MUL) / divisor (DIV)
    logic        r_is_div;
    logic        r_is_rem;
    logic        r_word;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;

    logic        w_is_div, w_is_rem, w_signed, w_zext;
    logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic        w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [63:0] w_fast_raw, w_fast;
    logic [64:0] w_shift, w_trial;
    logic [63:0] w_x_n, w_y_n, w_z_n, w_raw, w_final;

    // Operand decode and preparation in the accept cycle
    always_comb begin
        w_is_div = (op >= 3'd1) && (op <= 3'd4);
        w_is_rem = (op == 3'd3) || (op == 3'd4);
        w_signed = (op == 3'd1) || (op == 3'd3);
        w_zext   = (op == 3'd2) || (op == 3'd4);
        w_a_ext  = a;
        w_b_ext  = b;
        if (word) begin
            w_a_ext = w_zext ? {32'd0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            w_b_ext = w_zext ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        w_a_neg = w_signed & w_a_ext[63];
        w_b_neg = w_signed & w_b_ext[63];
        w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
        w_div0  = w_is_div & (w_b_ext == 64'd0);
        w_ovf   = w_is_div & w_signed & (w_b_ext == {64{1'b1}}) &
                  (w_a_ext == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (w_div0)
            w_fast_raw = w_is_rem ? w_a_ext : {64{1'b1}};
        else
            w_fast_raw = w_is_rem ? 64'd0 : w_a_ext;
        w_fast = word ? {{32{w_fast_raw[31]}}, w_fast_raw[31:0]} : w_fast_raw;
    end

    // One iteration of the selected algorithm plus final sign fix-up
    always_comb begin
        w_shift = {r_x, r_y[63]};
        w_trial = w_shift - {1'b0, r_z};
        w_z_n   = r_z;
        if (r_is_div) begin
            w_x_n = w_trial[64] ? w_shift[63:0] : w_trial[63:0];
            w_y_n = {r_y[62:0], ~w_trial[64]};
        end else begin
            w_x_n = r_x + (r_y[0] ? r_z : 64'd0);
            w_y_n = {1'b0, r_y[63:1]};
            w_z_n = {r_z[62:0], 1'b0};
        end
        if (!r_is_div)
            w_raw = w_x_n;
        else if (r_is_rem)
            w_raw = r_neg_r ? -w_x_n : w_x_n;
        else
            w_raw = r_neg_q ? -w_y_n : w_y_n;
        w_final = r_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 7'd0;
            r_x      <= 64'd0;
            r_y      <= 64'd0;
            r_z      <= 64'd0;
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 64'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_is_div <= w_is_div;
                        r_is_rem <= w_is_rem;
                        r_word   <= word;
                        r_neg_q  <= (w_a_neg ^ w_b_neg) & (w_b_ext != 64'd0);
                        r_neg_r  <= w_a_neg;
                        r_cnt    <= word ? 7'd32 : 7'd64;
                        r_x      <= 64'd0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_fast;
                            r_state  <= S_DONE;
                        end else begin
                            // Word divides start with the dividend in the upper
                            // half so 32 shifts leave the quotient in [31:0].
                            if (w_is_div) begin
                                r_y <= word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                                r_z <= w_b_mag;
                            end else begin
                                r_y <= w_b_ext;
                                r_z <= w_a_ext;
                            end
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_x   <= w_x_n;
                    r_y   <= w_y_n;
                    r_z   <= w_z_n;
                    r_cnt <= r_cnt - 7'd1;
                    if (r_cnt == 7'd1) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall  = valid_in & ~flush & (r_state != S_DONE);
    assign done   = (r_state == S_DONE);
    assign busy   = (r_state != S_IDLE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed self-checking bench for muldiv_seq.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [2:0]  op;
    logic        word;
    logic [63:0] a, b;
    logic        flush;
    logic        stall, done, busy;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_seq dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .op       (op),
        .word     (word),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Presents one op at posedge+1 (cycle 0) and returns when done has been seen.
    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x,
                          input logic [63:0] y, output int dcyc,
                          output logic [63:0] res, output int scnt);
        dcyc = -1;
        res  = 64'd0;
        scnt = 0;
        op = o; word = w; a = x; b = y; valid_in = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (stall) scnt++;
            if (done) begin
                dcyc = c;
                res  = result;
            end
            @(posedge clk); #1;
            if (dcyc >= 0) break;
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_tests++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int dc, sc; logic [63:0] r;
        run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, dc, r, sc);
        n_tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mul_result got %h want fffffffffffffffa", r); end
        n_tests++; if (dc !== 65) begin n_fail++; $display("FAIL mul_done_cycle got %0d want 65", dc); end
        n_tests++; if (sc !== 65) begin n_fail++; $display("FAIL mul_stall_cycles got %0d want 65", sc); end
        run_op(3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, dc, r, sc);
        n_tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mul_reserved got %h want fffffffffffffff1", r); end
    endtask

    task automatic test_div();
        int dc, sc; logic [63:0] r;
        run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, dc, r, sc);
        n_tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg got %h want fffffffffffffffd", r); end
        n_tests++; if (dc !== 65) begin n_fail++; $display("FAIL div_done_cycle got %0d want 65", dc); end
        run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, dc, r, sc);
        n_tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL rem_neg got %h want ffffffffffffffff", r); end
        run_op(3'd2, 1'b0, 64'd100, 64'd7, dc, r, sc);
        n_tests++; if (r !== 64'd14) begin n_fail++; $display("FAIL divu got %h want 14", r); end
        run_op(3'd4, 1'b0, 64'd100, 64'd7, dc, r, sc);
        n_tests++; if (r !== 64'd2) begin n_fail++; $display("FAIL remu got %h want 2", r); end
    endtask

    task automatic test_fast();
        int dc, sc; logic [63:0] r;
        run_op(3'd2, 1'b0, 64'd5, 64'd0, dc, r, sc);
        n_tests++; if (r !== {64{1'b1}}) begin n_fail++; $display("FAIL divu_by0 got %h want all ones", r); end
        n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL divu_by0_cycle got %0d want 1", dc); end
        n_tests++; if (sc !== 1) begin n_fail++; $display("FAIL divu_by0_stall got %0d want 1", sc); end
        run_op(3'd3, 1'b0, 64'd5, 64'd0, dc, r, sc);
        n_tests++; if (r !== 64'd5) begin n_fail++; $display("FAIL rem_by0 got %h want 5", r); end
        run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, dc, r, sc);
        n_tests++; if (r !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL div_ovf got %h want 8000000000000000", r); end
        n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL div_ovf_cycle got %0d want 1", dc); end
    endtask

    task automatic test_word();
        int dc, sc; logic [63:0] r;
        run_op(3'd2, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, dc, r, sc);
        n_tests++; if (r !== {64{1'b1}}) begin n_fail++; $display("FAIL divuw got %h want all ones", r); end
        n_tests++; if (dc !== 33) begin n_fail++; $display("FAIL divuw_cycle got %0d want 33", dc); end
        run_op(3'd0, 1'b1, 64'h1_0000, 64'h1_0000, dc, r, sc);
        n_tests++; if (r !== 64'd0) begin n_fail++; $display("FAIL mulw got %h want 0", r); end
        run_op(3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, dc, r, sc);
        n_tests++; if (r !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL divw_ovf got %h want ffffffff80000000", r); end
    endtask

    task automatic test_flush();
        int dc, sc; logic [63:0] r; logic seen;
        op = 3'd1; word = 1'b0; a = 64'd1000; b = 64'd3; valid_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy got %b want 0", busy); end
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done got %b want 0", seen); end
        run_op(3'd0, 1'b0, 64'd6, 64'd7, dc, r, sc);
        n_tests++; if (r !== 64'd42) begin n_fail++; $display("FAIL mul_after_flush got %h want 42", r); end
        n_tests++; if (dc !== 65) begin n_fail++; $display("FAIL mul_after_flush_cycle got %0d want 65", dc); end
    endtask

    task automatic test_reset_midrun();
        int dc, sc; logic [63:0] r;
        op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd5; valid_in = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        valid_in = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done); end
        n_tests++; if (result !== 64'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", result); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(3'd4, 1'b0, 64'd9, 64'd4, dc, r, sc);
        n_tests++; if (r !== 64'd1) begin n_fail++; $display("FAIL remu_after_rst got %h want 1", r); end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; op = 3'd0; word = 1'b0;
        a = 64'd0; b = 64'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_mul();
        test_div();
        test_fast();
        test_word();
        test_flush();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 64-bit multiply/divide sequencer for the execute stage. Accepts one M-extension operation from execute, runs a shift-add multiply or restoring divide one bit per cycle, and stalls the pipeline until the result is ready. Results are handed back in a one-cycle `done` pulse alongside the ALU result path. Architectural special cases (divide-by-zero, signed overflow) take a 1-cycle fast path.

## Interface
- No parameters; XLEN fixed at 64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  execute holds an M-op; `op`, `word`, `a`, `b` are stable while `stall` is high.
- `op`  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5–7 are reserved and treated as MUL.
- `word`  in  1  W-variant: use `a[31:0]`/`b[31:0]`; result is the 32-bit result sign-extended.
- `a`, `b`  in  64  rs1 / rs2 values (`srca`/`srcb`).
- `flush`  in  1  kill the in-flight op (branch mispredict/exception).
- `stall`  out  1  freeze fetch..execute.
- `done`  out  1  one-cycle pulse; `result` is valid this cycle.
- `result`  out  64  product low half, quotient or remainder.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `valid_in & ~flush`: latch the operands, then go to DONE (fast path) or RUN.
  - Load the counter with N: 64, or 32 when `word`=1.
- RUN:
  - One iteration per cycle; decrement the counter.
  - At counter 1, apply the sign fix-up and register `result`, then go to DONE.
- DONE: assert `done`; next state is IDLE unconditionally.
- Operand preparation:
  - Word mode: signed ops (MUL, DIV, REM) sign-extend from bit 31; DIVU/REMU zero-extend.
  - Signed divide uses magnitudes.
  - Quotient is negated iff the operand signs differ and the divisor ≠ 0.
  - Remainder takes the sign of the dividend.
- MUL: unsigned shift-add over N multiplier bits. The low N bits are sign-agnostic; upper bits are discarded.
- Divide: restoring. Per step, shift the {rem, quo} pair left 1, trial-subtract the divisor, and keep the subtraction if it is non-negative (set the quotient bit).
- Fast path (skips RUN):
  - Divisor = 0: quotient = all ones; remainder = dividend (word: sext(a[31:0])).
  - Signed overflow (dividend = most-negative, divisor = −1): quotient = dividend, remainder = 0. Word mode: dividend 0x8000_0000, giving quotient 0xFFFF_FFFF_8000_0000.
- Word result: `result = {{32{r[31]}}, r[31:0]}` for all ops, including DIVU/REMU.
- `flush`:
  - Synchronous, highest priority.
  - In any state, next state is IDLE, `done` is not asserted, and `result` is left unchanged.
  - A `flush` in the same cycle as `done` does not suppress that `done`; the pipeline discards it.
- Reserved `op` codes behave exactly as MUL. Inputs change only while `stall`=0.

## Timing
- Reset values: IDLE; `done`=0, `busy`=0, `stall`=0, `result`=0, counter=0.
- `stall` is combinational: `valid_in & ~flush & (state ≠ DONE)`.
  - High in the accept cycle and every RUN cycle; low in DONE, so execute advances on that edge.
- Normal op accepted in cycle 0: RUN in cycles 1..N, DONE in cycle N+1.
  - 64-bit: `done` in cycle 65, `stall` high for cycles 0–64.
  - Word: `done` in cycle 33.
- Fast path: accepted in cycle 0, `done` in cycle 1, `stall` high in cycle 0 only.
- Back-to-back ops: the next op is presented after the DONE edge and accepted from IDLE, so there is a minimum 1 idle-accept cycle between ops.
- Reset asserted mid-RUN: immediate (async) return to the reset values; no `done`.

## Test plan
- MUL, a=3, b=0xFFFF_FFFF_FFFF_FFFE (−2) → `done` at cycle 65, `result`=0xFFFF_FFFF_FFFF_FFFA; `stall` high for exactly 65 cycles.
- DIV a=−7, b=2 → `result`=0xFFFF_FFFF_FFFF_FFFD (−3). REM same operands → 0xFFFF_FFFF_FFFF_FFFF (−1). DIVU a=100, b=7 → 14. REMU a=100, b=7 → 2.
- DIVU a=5, b=0 → `done` at cycle 1, `result`=all ones. REM a=5, b=0 → 5. DIV a=0x8000_0000_0000_0000, b=−1 → `result`=0x8000_0000_0000_0000 in cycle 1.
- Word mode: DIVUW a=0xFFFF_FFFF, b=1 → `result`=0xFFFF_FFFF_FFFF_FFFF at cycle 33. MULW a=0x10000, b=0x10000 → 0.
- `flush` at cycle 20 of a 64-bit DIV → IDLE next cycle, `done` never pulses. A new MUL 6×7 then yields 42 at cycle 65 of its own accept.
- `reset` pulsed mid-RUN → outputs return to 0 asynchronously. A subsequent REMU a=9, b=4 → 1.
